serial_word_receiver: RTL and testbench

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

---
 rtl/serial_word_receiver.sv | 120 ++++++++++++
 tb/tb_serial_word_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with a one-word output register.
// Bit order is chosen per word, and a word that completes while the output is still held is dropped.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             order;
    logic             order_next;
    logic [WIDTH-1:0] q_next;
    logic             q_valid_next;
    logic             overrun_next;
    logic             word_done;

    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] cur,
        input logic             bit_in,
        input logic             msb
    );
        if (msb) begin
            return {cur[WIDTH-2:0], bit_in};
        end
        return {bit_in, cur[WIDTH-1:1]};
    endfunction

    // State register: every register clears on reset, data included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            order   <= 1'b0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            sr      <= sr_next;
            order   <= order_next;
            q       <= q_next;
            q_valid <= q_valid_next;
            overrun <= overrun_next;
        end
    end

    // Next-state logic: the first bit of a word fixes its bit order.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        order_next = order;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (sin_valid) begin
                    order_next = msb_first;
                    sr_next    = shift_in(sr, sin, msb_first);
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    sr_next = shift_in(sr, sin, order);
                    if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        word_done  = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // Output logic: a consume on the same edge frees the slot for the new word.
    always_comb begin
        q_next       = q;
        q_valid_next = q_valid;
        overrun_next = 1'b0;
        busy         = (state == SHIFT);
        if (word_done) begin
            if (!q_valid || q_ready) begin
                q_next       = sr_next;
                q_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (q_valid && q_ready) begin
            q_valid_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed scenarios plus a randomized run
// against a bit-queue reference model of word assembly and output handshake.
module tb_serial_word_receiver;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             msb_first = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready = 1'b0;
    logic             busy;
    logic             overrun;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit               m_bits[$];
    bit               m_order;
    logic [WIDTH-1:0] exp_q = '0;
    logic             exp_qv = 1'b0;
    logic             exp_ov = 1'b0;
    logic             exp_busy = 1'b0;

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .sin(sin),
        .sin_valid(sin_valid),
        .msb_first(msb_first),
        .q(q),
        .q_valid(q_valid),
        .q_ready(q_ready),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Drives one clock of inputs, advances the model, and returns 1 time unit after the edge.
    task automatic cycle(input logic r, input logic v, input logic b, input logic msb, input logic rdy);
        logic [WIDTH-1:0] word;
        logic             done;
        logic             consume;
        reset     = r;
        sin_valid = v;
        sin       = b;
        msb_first = msb;
        q_ready   = rdy;
        @(posedge clk);
        done = 1'b0;
        word = '0;
        if (r) begin
            m_bits.delete();
            m_order = 1'b0;
            exp_q   = '0;
            exp_qv  = 1'b0;
            exp_ov  = 1'b0;
        end else begin
            consume = exp_qv && rdy;
            exp_ov  = 1'b0;
            if (v) begin
                if (m_bits.size() == 0) m_order = msb;
                m_bits.push_back(b);
                if (m_bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (m_order) word[WIDTH-1-i] = m_bits[i];
                        else         word[i] = m_bits[i];
                    end
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!exp_qv || rdy) begin
                    exp_q  = word;
                    exp_qv = 1'b1;
                end else begin
                    exp_ov = 1'b1;
                end
            end else if (consume) begin
                exp_qv = 1'b0;
            end
        end
        exp_busy = (m_bits.size() != 0);
        #1;
    endtask

    // Sends seq[WIDTH-1] first; q_ready is held low except on the final bit.
    task automatic send_word(input logic [WIDTH-1:0] seq, input logic msb, input logic rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b1, seq[i], msb, (i == 0) ? rdy_last : 1'b0);
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        total++; if (q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b want=%b", q, 4'b0000); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b want=0", q_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_msb_first();
        logic [WIDTH-1:0] seq;
        seq = 4'b1000;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b1, seq[i], 1'b1, 1'b0);
            if (i > 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL msb_busy bit=%0d got=%b want=1", WIDTH - 1 - i, busy); end
                total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL msb_early_valid got=%b want=0", q_valid); end
            end
        end
        total++; if (q !== 4'b1000) begin bad++; $display("FAIL msb_q got=%b want=%b", q, 4'b1000); end
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL msb_q_valid got=%b want=1", q_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL msb_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_lsb_gaps();
        logic [WIDTH-1:0] seq;
        seq = 4'b1000;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b1, seq[i], (i == WIDTH - 1) ? 1'b0 : 1'b1, 1'b0);
            if (i > 0) begin
                for (int g = 0; g < 2; g++) begin
                    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lsb_gap_busy got=%b want=1", busy); end
                end
            end
        end
        total++; if (q !== 4'b0001) begin bad++; $display("FAIL lsb_q got=%b want=%b", q, 4'b0001); end
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL lsb_q_valid got=%b want=1", q_valid); end
    endtask

    task automatic test_overrun();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b0110, 1'b1, 1'b0);
        total++; if (q !== 4'b0110) begin bad++; $display("FAIL ovr_first_q got=%b want=%b", q, 4'b0110); end
        send_word(4'b1111, 1'b1, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
        total++; if (q !== 4'b0110) begin bad++; $display("FAIL ovr_q_kept got=%b want=%b", q, 4'b0110); end
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL ovr_q_valid got=%b want=1", q_valid); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle got=%b want=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_busy got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        send_word(4'b1001, 1'b1, 1'b1);
        total++; if (q !== 4'b1001) begin bad++; $display("FAIL b2b_q got=%b want=%b", q, 4'b1001); end
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL b2b_q_valid got=%b want=1", q_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_handshake();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL hs_q_valid got=%b want=0", q_valid); end
        total++; if (q !== 4'b1001) begin bad++; $display("FAIL hs_q_held got=%b want=%b", q, 4'b1001); end
    endtask

    task automatic test_reset_mid_word();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%b want=0", busy); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL rmw_q_valid got=%b want=0", q_valid); end
        send_word(4'b0110, 1'b1, 1'b0);
        total++; if (q !== 4'b0110) begin bad++; $display("FAIL rmw_q got=%b want=%b", q, 4'b0110); end
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL rmw_q_valid_end got=%b want=1", q_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rmw_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_random();
        logic r;
        logic v;
        logic b;
        logic m;
        logic rdy;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 79) == 0);
            v   = ($urandom_range(0, 1) == 1);
            b   = 1'($urandom);
            m   = 1'($urandom);
            rdy = ($urandom_range(0, 9) < 3);
            cycle(r, v, b, m, rdy);
            total++; if (q !== exp_q) begin bad++; $display("FAIL rnd_q cyc=%0d got=%b want=%b", n, q, exp_q); end
            total++; if (q_valid !== exp_qv) begin bad++; $display("FAIL rnd_q_valid cyc=%0d got=%b want=%b", n, q_valid, exp_qv); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", n, busy, exp_busy); end
            total++; if (overrun !== exp_ov) begin bad++; $display("FAIL rnd_overrun cyc=%0d got=%b want=%b", n, overrun, exp_ov); end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_overrun();
        test_back_to_back();
        test_handshake();
        test_reset_mid_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
